// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, memory-wait stalls and branch flush
// sequencing, with stall and load-use performance counters.
//
// state   | meaning
// RUN     | normal issue; load-use detection enabled
// LU_HOLD | load-use bubble inserted last cycle; detection suppressed
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       id_ex_opcode,
   input  logic [4:0]       id_ex_rs1_s,
   input  logic [4:0]       id_ex_rs2_s,
   input  logic [6:0]       ex_mem_opcode,
   input  logic [4:0]       ex_mem_rd_s,
   input  logic             ex_mem_regf_we,
   input  logic             flush_req,
   input  logic             imem_req,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_stall,
   output logic             ex_mem_stall,
   output logic             mem_wb_stall,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] load_use_cnt
);

   typedef enum logic {RUN = 1'b0, LU_HOLD = 1'b1} state_t;

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   state_t state, state_nxt;
   logic   flush_pend, flush_pend_nxt;
   logic   dwait, iwait;
   logic   use_rs1, use_rs2, rs1_hit, rs2_hit;
   logic   lu, lu_act, flush_act;

   assign dwait = dmem_req & ~dmem_resp;
   assign iwait = imem_req & ~imem_resp;

   assign use_rs1 = (id_ex_opcode == OP_IMM)  || (id_ex_opcode == OP_REG)
                 || (id_ex_opcode == OP_BR)   || (id_ex_opcode == OP_LOAD)
                 || (id_ex_opcode == OP_STORE) || (id_ex_opcode == OP_JALR);
   assign use_rs2 = (id_ex_opcode == OP_REG) || (id_ex_opcode == OP_BR)
                 || (id_ex_opcode == OP_STORE);

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign rs1_hit = use_rs1 && (id_ex_rs1_s != 5'd0) && (id_ex_rs1_s == ex_mem_rd_s);
   assign rs2_hit = use_rs2 && (id_ex_rs2_s != 5'd0) && (id_ex_rs2_s == ex_mem_rd_s);

   assign lu = (state == RUN) && (ex_mem_opcode == OP_LOAD) && ex_mem_regf_we
            && !flush_req && (rs1_hit || rs2_hit);

   // Priority: dmem wait > imem wait > load-use > flush
   assign lu_act    = lu && !dwait && !iwait;
   assign flush_act = (flush_req || flush_pend) && !dwait && !iwait && !lu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt    <= '0;
         load_use_cnt <= '0;
      end else begin
         if (pc_stall) stall_cnt    <= stall_cnt + CNT_W'(1);
         if (lu_act)   load_use_cnt <= load_use_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (lu_act) state_nxt = LU_HOLD;
         LU_HOLD: if (!dwait) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // A redirect that arrives while a memory wait blocks it is remembered until it can issue
   always_comb begin
      flush_pend_nxt = flush_pend;
      if (flush_act)
         flush_pend_nxt = 1'b0;
      else if (flush_req && (dwait || iwait))
         flush_pend_nxt = 1'b1;
   end

   always_comb begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      id_ex_stall   = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_stall  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      if (!rst) begin
         if (dwait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
         end else if (iwait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (lu_act) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
         end else if (flush_act) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end
      end
   end

endmodule
